// File: rtl/cam_pkg.sv
// Shared definitions for the CAM parallel-processor array: op codes, FSM states
// and the width helpers for the paired-bit mismatch/write operand buses.
package cam_pkg;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_SEARCH    = 3'd1;
  localparam logic [2:0] OP_SRCH_AND  = 3'd2;
  localparam logic [2:0] OP_SRCH_OR   = 3'd3;
  localparam logic [2:0] OP_WRITE     = 3'd4;
  localparam logic [2:0] OP_READ      = 3'd5;
  localparam logic [2:0] OP_SEL_FIRST = 3'd6;
  localparam logic [2:0] OP_SET_ALL   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int match_w(input int width);
    return 2 * width;
  endfunction

  function automatic int write_w(input int width);
    return 2 * width;
  endfunction

  function automatic logic is_search(input logic [2:0] op);
    return (op == OP_SEARCH) || (op == OP_SRCH_AND) || (op == OP_SRCH_OR);
  endfunction

endpackage

// File: rtl/cam_row.sv
// One CAM row: stored word, ternary mismatch compare against the key bus, and
// a per-bit masked write where a conflicting bit pair leaves the bit untouched.
module cam_row
  import cam_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_wr_en,
  input  logic [write_w(WIDTH)-1:0]   i_write,
  input  logic [match_w(WIDTH)-1:0]   i_mismatch,
  output logic                        o_match,
  output logic [WIDTH-1:0]            o_word
);

  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] w_miss;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word <= '0;
    end else if (i_wr_en) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (i_write[2*j] && !i_write[2*j+1]) begin
          r_word[j] <= 1'b1;
        end else if (i_write[2*j+1] && !i_write[2*j]) begin
          r_word[j] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_miss = '0;
    for (int j = 0; j < WIDTH; j++) begin
      w_miss[j] = (i_mismatch[2*j+1] & r_word[j]) | (i_mismatch[2*j] & ~r_word[j]);
    end
  end

  assign o_match = ~|w_miss;
  assign o_word  = r_word;

endmodule

// File: rtl/cam_array_seq.sv
// CAM array top: op handshake FSM, banked search with shadow match vector,
// tag register, OR-reduce read tree and first-responder select.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  ST_IDLE | waiting for an op, cmd_ready=1
//  ST_SCAN | banked search in progress, one bank of rows per cycle
//  ST_DONE | resp_valid pulse, outputs updated, next op may be accepted
module cam_array_seq
  import cam_pkg::*;
#(
  parameter int WORDS = 100,
  parameter int WIDTH = 32,
  parameter int BANKS = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [2:0]                  cmd_op,
  input  logic [match_w(WIDTH)-1:0]   mismatch_in,
  input  logic [write_w(WIDTH)-1:0]   write_in,
  output logic                        resp_valid,
  output logic [WORDS-1:0]            tags,
  output logic                        any_tag,
  output logic [WIDTH-1:0]            read_lines
);

  localparam int ROWS_PB = WORDS / BANKS;
  localparam int BANK_W  = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(BANKS - 1);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [BANK_W-1:0]           r_bank;
  logic [2:0]                  r_op;
  logic [match_w(WIDTH)-1:0]   r_mismatch;
  logic [WORDS-1:0]            r_tags;
  logic [WORDS-1:0]            r_shadow;
  logic [WIDTH-1:0]            r_read_lines;

  logic                        w_accept;
  logic                        w_search_done;
  logic [2:0]                  w_op;
  logic [match_w(WIDTH)-1:0]   w_key;
  logic [WORDS-1:0]            w_match;
  logic [WORDS-1:0]            w_combined;
  logic [WORDS-1:0]            w_sel_first;
  logic [WIDTH-1:0]            w_read_or;
  logic [WIDTH-1:0]            w_row_word [WORDS];

  assign w_accept = cmd_valid & cmd_ready;
  assign w_op     = w_accept ? cmd_op : r_op;
  // Bank 0 is compared in the acceptance cycle straight off the input bus.
  assign w_key    = w_accept ? mismatch_in : r_mismatch;

  for (genvar i = 0; i < WORDS; i++) begin : g_row
    localparam logic [BANK_W-1:0] ROW_BANK = BANK_W'(i / ROWS_PB);

    cam_row #(.WIDTH(WIDTH)) u_row (
      .clk        (clk),
      .rst        (rst),
      .i_wr_en    (w_accept && (cmd_op == OP_WRITE) && r_tags[i]),
      .i_write    (write_in),
      .i_mismatch (w_key),
      .o_match    (w_match[i]),
      .o_word     (w_row_word[i])
    );

    assign w_combined[i] = (r_bank == ROW_BANK) ? w_match[i] : r_shadow[i];
  end

  assign w_search_done = is_search(w_op) &&
                         ((w_accept && (BANKS == 1)) ||
                          ((r_state == ST_SCAN) && (r_bank == LAST_BANK)));

  assign w_sel_first = r_tags & (~r_tags + WORDS'(1));

  always_comb begin
    w_read_or = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (r_tags[i]) w_read_or = w_read_or | w_row_word[i];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    resp_valid  = 1'b0;
    case (r_state)
      ST_IDLE: cmd_ready = 1'b1;
      ST_SCAN: if (r_bank == LAST_BANK) w_state_nxt = ST_DONE;
      ST_DONE: begin
        cmd_ready   = 1'b1;
        resp_valid  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (cmd_valid && (r_state != ST_SCAN)) begin
      w_state_nxt = (is_search(cmd_op) && (BANKS > 1)) ? ST_SCAN : ST_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank       <= '0;
      r_op         <= OP_NOP;
      r_mismatch   <= '0;
      r_tags       <= '0;
      r_shadow     <= '0;
      r_read_lines <= '0;
    end else begin
      if (w_accept) begin
        r_op       <= cmd_op;
        r_mismatch <= mismatch_in;
      end
      if (w_accept && is_search(cmd_op) && (BANKS > 1)) begin
        r_bank <= BANK_W'(1);
      end else if (r_state == ST_SCAN) begin
        r_bank <= (r_bank == LAST_BANK) ? '0 : r_bank + 1'b1;
      end
      if (w_accept || (r_state == ST_SCAN)) r_shadow <= w_combined;
      if (w_search_done) begin
        case (w_op)
          OP_SEARCH:   r_tags <= w_combined;
          OP_SRCH_AND: r_tags <= r_tags & w_combined;
          default:     r_tags <= r_tags | w_combined;
        endcase
      end else if (w_accept) begin
        case (cmd_op)
          OP_SEL_FIRST: r_tags <= w_sel_first;
          OP_SET_ALL:   r_tags <= '1;
          default:      r_tags <= r_tags;
        endcase
      end
      if (w_accept && (cmd_op == OP_READ)) r_read_lines <= w_read_or;
    end
  end

  assign tags       = r_tags;
  assign any_tag    = |r_tags;
  assign read_lines = r_read_lines;

endmodule

// File: tb/tb_cam_array_seq.sv
// Bench for cam_array_seq: a banked (BANKS=4) and an unbanked instance share
// one stimulus stream and are both checked against an array-level model.
module tb_cam_array_seq;
  import cam_pkg::*;

  localparam int WORDS   = 100;
  localparam int WIDTH   = 32;
  localparam int BANKS_A = 4;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid;
  logic [2:0] cmd_op;
  logic [2*WIDTH-1:0] mismatch_in;
  logic [2*WIDTH-1:0] write_in;
  logic cmd_ready_a, resp_valid_a, any_tag_a;
  logic cmd_ready_b, resp_valid_b, any_tag_b;
  logic [WORDS-1:0] tags_a, tags_b;
  logic [WIDTH-1:0] read_lines_a, read_lines_b;

  always #5 clk = ~clk;

  cam_array_seq #(.WORDS(WORDS), .WIDTH(WIDTH), .BANKS(BANKS_A)) dut_a (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_a),
    .cmd_op(cmd_op), .mismatch_in(mismatch_in), .write_in(write_in),
    .resp_valid(resp_valid_a), .tags(tags_a), .any_tag(any_tag_a),
    .read_lines(read_lines_a));

  cam_array_seq #(.WORDS(WORDS), .WIDTH(WIDTH), .BANKS(1)) dut_b (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b),
    .cmd_op(cmd_op), .mismatch_in(mismatch_in), .write_in(write_in),
    .resp_valid(resp_valid_b), .tags(tags_b), .any_tag(any_tag_b),
    .read_lines(read_lines_b));

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [WIDTH-1:0] m_store [WORDS];
  logic [WORDS-1:0] m_tags;
  logic [WIDTH-1:0] m_read;

  // observations of the last op
  int lat_a, lat_b;
  logic [WORDS-1:0] st_a, st_b;
  logic an_a, an_b;
  logic [WIDTH-1:0] rd_a, rd_b;
  logic rdy_before, scan_rdy, extra_resp;

  function automatic logic [2*WIDTH-1:0] key_mm(input logic [WIDTH-1:0] key,
                                                input logic [WIDTH-1:0] care);
    logic [2*WIDTH-1:0] r = '0;
    for (int j = 0; j < WIDTH; j++)
      if (care[j]) begin
        if (key[j]) r[2*j] = 1'b1;
        else        r[2*j+1] = 1'b1;
      end
    return r;
  endfunction

  function automatic logic [2*WIDTH-1:0] wr_val(input logic [WIDTH-1:0] val,
                                                input logic [WIDTH-1:0] en);
    logic [2*WIDTH-1:0] r = '0;
    for (int j = 0; j < WIDTH; j++)
      if (en[j]) begin
        if (val[j]) r[2*j] = 1'b1;
        else        r[2*j+1] = 1'b1;
      end
    return r;
  endfunction

  function automatic logic [WORDS-1:0] rows3(input int a, input int b, input int c);
    logic [WORDS-1:0] r = '0;
    if (a >= 0) r[a] = 1'b1;
    if (b >= 0) r[b] = 1'b1;
    if (c >= 0) r[c] = 1'b1;
    return r;
  endfunction

  function automatic logic [WORDS-1:0] model_match(input logic [2*WIDTH-1:0] mm);
    logic [WORDS-1:0] r = '0;
    for (int i = 0; i < WORDS; i++) begin
      logic hit = 1'b1;
      for (int j = 0; j < WIDTH; j++)
        if (m_store[i][j] ? mm[2*j+1] : mm[2*j]) hit = 1'b0;
      r[i] = hit;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < WORDS; i++) m_store[i] = '0;
    m_tags = '0;
    m_read = '0;
  endtask

  task automatic model_apply(input logic [2:0] op, input logic [2*WIDTH-1:0] mm,
                             input logic [2*WIDTH-1:0] wr);
    logic found;
    case (op)
      3'd1: m_tags = model_match(mm);
      3'd2: m_tags = m_tags & model_match(mm);
      3'd3: m_tags = m_tags | model_match(mm);
      3'd4:
        for (int i = 0; i < WORDS; i++)
          if (m_tags[i])
            for (int j = 0; j < WIDTH; j++) begin
              if (wr[2*j] && !wr[2*j+1]) m_store[i][j] = 1'b1;
              else if (wr[2*j+1] && !wr[2*j]) m_store[i][j] = 1'b0;
            end
      3'd5: begin
        m_read = '0;
        for (int i = 0; i < WORDS; i++) if (m_tags[i]) m_read = m_read | m_store[i];
      end
      3'd6: begin
        found = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
          if (found) m_tags[i] = 1'b0;
          else if (m_tags[i]) found = 1'b1;
        end
      end
      3'd7: m_tags = '1;
      default: ;
    endcase
  endtask

  // Issue one op to both instances and record what each returns.
  task automatic do_op(input logic [2:0] op, input logic [2*WIDTH-1:0] mm,
                       input logic [2*WIDTH-1:0] wr);
    @(negedge clk);
    rdy_before = cmd_ready_a & cmd_ready_b;
    cmd_valid = 1'b1; cmd_op = op; mismatch_in = mm; write_in = wr;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom_range(0, 7));
    mismatch_in = {$urandom, $urandom};
    write_in = {$urandom, $urandom};
    lat_a = 0; lat_b = 0; scan_rdy = 1'b0;
    for (int k = 1; k <= 12 && (lat_a == 0 || lat_b == 0); k++) begin
      if (k > 1) @(negedge clk);
      if (resp_valid_b && lat_b == 0) begin
        lat_b = k; st_b = tags_b; an_b = any_tag_b; rd_b = read_lines_b;
      end
      if (resp_valid_a && lat_a == 0) begin
        lat_a = k; st_a = tags_a; an_a = any_tag_a; rd_a = read_lines_a;
      end else if (lat_a == 0 && cmd_ready_a) begin
        scan_rdy = 1'b1;
      end
    end
    @(negedge clk);
    extra_resp = resp_valid_a | resp_valid_b;
    model_apply(op, mm, wr);
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; mismatch_in = '0; write_in = '0;
    repeat (3) @(negedge clk);
    model_reset();
    checks++;
    if ({cmd_ready_a, cmd_ready_b, resp_valid_a, resp_valid_b} !== 4'b1100) begin
      errors++; $display("FAIL reset_handshake got %b exp 1100",
                         {cmd_ready_a, cmd_ready_b, resp_valid_a, resp_valid_b});
    end
    checks++;
    if (tags_a !== '0 || tags_b !== '0 || any_tag_a !== 1'b0 || any_tag_b !== 1'b0) begin
      errors++; $display("FAIL reset_tags got %h/%h exp 0", tags_a, tags_b);
    end
    checks++;
    if (read_lines_a !== '0 || read_lines_b !== '0) begin
      errors++; $display("FAIL reset_read got %h/%h exp 0", read_lines_a, read_lines_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_load_search();
    logic [WIDTH-1:0] vals [4] = '{456, 457, 457, 1000};
    int idx [4] = '{0, 1, 5, 4};
    do_op(OP_SET_ALL, '0, '0);
    // Give rows 0..5 unique markers by repeatedly picking the first all-zero row.
    for (int i = 0; i < 6; i++) begin
      do_op(OP_SEARCH, key_mm('0, '1), '0);
      do_op(OP_SEL_FIRST, '0, '0);
      do_op(OP_WRITE, '0, wr_val(32'h10000 + WIDTH'(i), '1));
    end
    for (int k = 0; k < 4; k++) begin
      do_op(OP_SEARCH, key_mm(32'h10000 + WIDTH'(idx[k]), '1), '0);
      do_op(OP_WRITE, '0, wr_val(vals[k], '1));
    end
    do_op(OP_SEARCH, key_mm(457, '1), '0);
    checks++;
    if (st_a !== rows3(1, 5, -1) || st_b !== rows3(1, 5, -1)) begin
      errors++; $display("FAIL search_457 got %h/%h exp %h", st_a, st_b, rows3(1, 5, -1));
    end
    checks++;
    if (an_a !== 1'b1 || an_b !== 1'b1) begin
      errors++; $display("FAIL search_457_any got %b/%b exp 1", an_a, an_b);
    end
  endtask

  task automatic test_dont_care();
    do_op(OP_SEARCH, key_mm(456, ~32'h1), '0);
    checks++;
    if (st_a !== rows3(0, 1, 5) || st_b !== rows3(0, 1, 5)) begin
      errors++; $display("FAIL dont_care got %h/%h exp %h", st_a, st_b, rows3(0, 1, 5));
    end
    do_op(OP_SEL_FIRST, '0, '0);
    checks++;
    if (st_a !== rows3(0, -1, -1) || st_b !== rows3(0, -1, -1)) begin
      errors++; $display("FAIL sel_first got %h/%h exp %h", st_a, st_b, rows3(0, -1, -1));
    end
    do_op(OP_READ, '0, '0);
    checks++;
    if (rd_a !== 32'd456 || rd_b !== 32'd456) begin
      errors++; $display("FAIL read_456 got %h/%h exp %h", rd_a, rd_b, 32'd456);
    end
  endtask

  task automatic test_write_bit31();
    do_op(OP_SEARCH, key_mm(457, '1), '0);
    do_op(OP_WRITE, '0, wr_val(32'h8000_0000, 32'h8000_0000));
    checks++;
    if (st_a !== rows3(1, 5, -1) || st_b !== rows3(1, 5, -1)) begin
      errors++; $display("FAIL write_keeps_tags got %h/%h exp %h", st_a, st_b, rows3(1, 5, -1));
    end
    do_op(OP_SEARCH, key_mm(32'h8000_01C9, '1), '0);
    checks++;
    if (st_a !== rows3(1, 5, -1) || st_b !== rows3(1, 5, -1)) begin
      errors++; $display("FAIL bit31_rows got %h/%h exp %h", st_a, st_b, rows3(1, 5, -1));
    end
    do_op(OP_SEARCH, key_mm(1000, '1), '0);
    do_op(OP_SRCH_OR, key_mm(456, '1), '0);
    checks++;
    if (st_a !== rows3(0, 4, -1) || st_b !== rows3(0, 4, -1)) begin
      errors++; $display("FAIL untouched_rows got %h/%h exp %h", st_a, st_b, rows3(0, 4, -1));
    end
    do_op(OP_READ, '0, '0);
    checks++;
    if (rd_a !== (32'd456 | 32'd1000) || rd_b !== (32'd456 | 32'd1000)) begin
      errors++; $display("FAIL read_or got %h/%h exp %h", rd_a, rd_b, 32'd456 | 32'd1000);
    end
  endtask

  task automatic test_banked_latency();
    do_op(OP_SEARCH, key_mm(32'h8000_01C9, '1), '0);
    checks++;
    if (lat_a !== BANKS_A || lat_b !== 1) begin
      errors++; $display("FAIL search_latency got %0d/%0d exp %0d/1", lat_a, lat_b, BANKS_A);
    end
    checks++;
    if (scan_rdy !== 1'b0 || extra_resp !== 1'b0 || rdy_before !== 1'b1) begin
      errors++; $display("FAIL scan_handshake got scan_rdy=%b extra=%b rdy=%b exp 0 0 1",
                         scan_rdy, extra_resp, rdy_before);
    end
    do_op(OP_NOP, '0, '0);
    checks++;
    if (lat_a !== 1 || lat_b !== 1 || st_a !== rows3(1, 5, -1)) begin
      errors++; $display("FAIL nop got lat %0d/%0d tags %h exp 1/1 %h",
                         lat_a, lat_b, st_a, rows3(1, 5, -1));
    end
  endtask

  task automatic test_and_zero_conflict();
    do_op(OP_SRCH_AND, key_mm(32'hDEAD_BEEF, '1), '0);
    checks++;
    if (st_a !== '0 || st_b !== '0 || an_a !== 1'b0 || an_b !== 1'b0) begin
      errors++; $display("FAIL and_zero got %h/%h any %b/%b exp 0", st_a, st_b, an_a, an_b);
    end
    do_op(OP_READ, '0, '0);
    checks++;
    if (rd_a !== '0 || rd_b !== '0) begin
      errors++; $display("FAIL read_zero got %h/%h exp 0", rd_a, rd_b);
    end
    do_op(OP_SET_ALL, '0, '0);
    do_op(OP_WRITE, '0, '1);
    do_op(OP_SEARCH, key_mm(32'h8000_01C9, '1), '0);
    do_op(OP_READ, '0, '0);
    checks++;
    if (st_a !== rows3(1, 5, -1) || rd_a !== 32'h8000_01C9 || rd_b !== 32'h8000_01C9) begin
      errors++; $display("FAIL conflict_write got tags %h read %h/%h exp %h %h",
                         st_a, rd_a, rd_b, rows3(1, 5, -1), 32'h8000_01C9);
    end
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [2*WIDTH-1:0] mm, wr;
    int exp_lat;
    for (int n = 0; n < 80; n++) begin
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) mm = '0;
      else mm = key_mm(m_store[$urandom_range(0, WORDS - 1)], $urandom | $urandom);
      if ($urandom_range(0, 7) == 0) mm[2*$urandom_range(0, WIDTH-1) +: 2] = 2'b11;
      wr = wr_val($urandom, $urandom);
      if ($urandom_range(0, 3) == 0) wr = wr | {$urandom, $urandom};
      do_op(op, mm, wr);
      exp_lat = (op >= 3'd1 && op <= 3'd3) ? BANKS_A : 1;
      checks++;
      if (lat_a !== exp_lat || lat_b !== 1) begin
        errors++; $display("FAIL rand_latency op %0d got %0d/%0d exp %0d/1", op, lat_a, lat_b, exp_lat);
      end
      checks++;
      if (st_a !== m_tags || st_b !== m_tags) begin
        errors++; $display("FAIL rand_tags op %0d got %h/%h exp %h", op, st_a, st_b, m_tags);
      end
      checks++;
      if (an_a !== (|m_tags) || an_b !== (|m_tags) || rd_a !== m_read || rd_b !== m_read) begin
        errors++; $display("FAIL rand_any_read op %0d got %b/%b %h/%h exp %b %h",
                           op, an_a, an_b, rd_a, rd_b, |m_tags, m_read);
      end
      checks++;
      if (rdy_before !== 1'b1 || scan_rdy !== 1'b0 || extra_resp !== 1'b0) begin
        errors++; $display("FAIL rand_handshake op %0d got rdy=%b scan_rdy=%b extra=%b exp 1 0 0",
                           op, rdy_before, scan_rdy, extra_resp);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    logic saw_resp = 1'b0;
    do_op(OP_SET_ALL, '0, '0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_SEARCH; mismatch_in = '0;
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++;
    if (cmd_ready_a !== 1'b1 || resp_valid_a !== 1'b0 || tags_a !== '0 || any_tag_a !== 1'b0) begin
      errors++; $display("FAIL mid_scan_reset got rdy=%b resp=%b tags=%h exp 1 0 0",
                         cmd_ready_a, resp_valid_a, tags_a);
    end
    for (int k = 0; k < 6; k++) begin
      if (resp_valid_a || resp_valid_b) saw_resp = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw_resp !== 1'b0) begin
      errors++; $display("FAIL mid_scan_no_resp got %b exp 0", saw_resp);
    end
    do_op(OP_SET_ALL, '0, '0);
    do_op(OP_READ, '0, '0);
    checks++;
    if (rd_a !== '0 || rd_b !== '0) begin
      errors++; $display("FAIL mid_scan_store got %h/%h exp 0", rd_a, rd_b);
    end
  endtask

  initial begin
    test_reset();
    test_load_search();
    test_dont_care();
    test_write_bit31();
    test_banked_latency();
    test_and_zero_conflict();
    test_random();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
